// File: rtl/adder_flag_monitor_pkg.sv
// Shared types for the adder flag monitor.
//   flag_t          : per-transaction flag payload carried in the output register
//   CNT_W_DEFAULT   : default statistics counter width
//   signed_ovf      : signed-overflow rule from operand/result sign bits
// Optional feature macro: PARITY_EN adds a parity bit to flag_t.
package adder_mon_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic negative;
    logic carry;
    logic mismatch;
`ifdef PARITY_EN
    logic parity;
`endif
  } flag_t;

  // Two same-sign operands producing an opposite-sign result.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb);
    return (~a_msb & ~b_msb & r_msb) | (a_msb & b_msb & ~r_msb);
  endfunction

endpackage

// File: rtl/adder_flag_monitor_if.sv
// Transaction and flag bus of the adder flag monitor.
//   Input side : in_valid/in_ready handshake, ain, bin, ci, result, co
//   Output side: out_valid/out_ready handshake, overflow, zero, negative,
//                carry, mismatch (+ parity when PARITY_EN is defined)
// slave  : the monitor; master : the producer/consumer around it.
interface adder_flag_monitor_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] ain;
  logic [WIDTH-1:0] bin;
  logic             ci;
  logic [WIDTH-1:0] result;
  logic             co;

  logic             out_valid;
  logic             out_ready;
  logic             overflow;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             mismatch;
`ifdef PARITY_EN
  logic             parity;
`endif

  modport slave (
`ifdef PARITY_EN
    output parity,
`endif
    input  in_valid, ain, bin, ci, result, co, out_ready,
    output in_ready, out_valid, overflow, zero, negative, carry, mismatch
  );

  modport master (
`ifdef PARITY_EN
    input  parity,
`endif
    output in_valid, ain, bin, ci, result, co, out_ready,
    input  in_ready, out_valid, overflow, zero, negative, carry, mismatch
  );

endinterface

// File: rtl/adder_flag_monitor_sat_counter.sv
// Saturating event counter with synchronous clear.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : clear; clr together with inc loads 1
//   inc        : count one event (holds at all-ones)
//   count      : registered count value
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear wins over the stored value but not over this event.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = CNT_W'(inc);
    end else if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/adder_flag_monitor.sv
// Registered status monitor for a WIDTH-bit adder.
//   clk, rst_n   : clock, synchronous active-low reset
//   mon (slave)  : transaction input handshake + registered flag output
//                  handshake (one-deep output register)
//   clr_sticky   : clear sticky_ov / sticky_err (a same-cycle set wins)
//   sticky_ov    : overflow seen since last clear
//   sticky_err   : mismatch seen since last clear
//   clr_stats    : clear counters (a same-cycle accept loads its increment)
//   txn_count    : accepted transactions (saturating)
//   ov_count     : accepted transactions with overflow (saturating)
//   err_count    : accepted transactions with mismatch (saturating)
// Optional feature macro: PARITY_EN adds the registered parity flag.
module adder_flag_monitor
  import adder_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_flag_monitor_if.slave  mon,
  input  logic                 clr_sticky,
  output logic                 sticky_ov,
  output logic                 sticky_err,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     txn_count,
  output logic [CNT_W-1:0]     ov_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam int unsigned SUM_W = WIDTH + 1;

  logic             accept_c;
  logic [SUM_W-1:0] ref_sum_c;
  flag_t            new_flags_c;

  logic  out_valid_q, out_valid_d;
  flag_t flags_q,     flags_d;
  logic  sticky_ov_q, sticky_ov_d;
  logic  sticky_err_q, sticky_err_d;

  // Ready whenever the output register is empty or being drained.
  assign mon.in_ready = ~out_valid_q | mon.out_ready;
  assign accept_c     = mon.in_valid & mon.in_ready;

  // Flags of the transaction currently on the input bus.
  always_comb begin
    ref_sum_c = SUM_W'(mon.ain) + SUM_W'(mon.bin) + SUM_W'(mon.ci);
    new_flags_c          = '0;
    new_flags_c.overflow = signed_ovf(mon.ain[WIDTH-1], mon.bin[WIDTH-1],
                                      mon.result[WIDTH-1]);
    new_flags_c.zero     = (mon.result == '0);
    new_flags_c.negative = mon.result[WIDTH-1];
    new_flags_c.carry    = mon.co;
    new_flags_c.mismatch = ({mon.co, mon.result} != ref_sum_c);
`ifdef PARITY_EN
    new_flags_c.parity   = ^mon.result;
`endif
  end

  // Output register and sticky flags next state.
  always_comb begin
    out_valid_d  = out_valid_q;
    flags_d      = flags_q;
    if (accept_c) begin
      out_valid_d = 1'b1;
      flags_d     = new_flags_c;
    end else if (mon.out_ready) begin
      out_valid_d = 1'b0;
    end
    sticky_ov_d  = (sticky_ov_q  & ~clr_sticky) | (accept_c & new_flags_c.overflow);
    sticky_err_d = (sticky_err_q & ~clr_sticky) | (accept_c & new_flags_c.mismatch);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      flags_q      <= '0;
      sticky_ov_q  <= 1'b0;
      sticky_err_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      flags_q      <= flags_d;
      sticky_ov_q  <= sticky_ov_d;
      sticky_err_q <= sticky_err_d;
    end
  end

  assign mon.out_valid = out_valid_q;
  assign mon.overflow  = flags_q.overflow;
  assign mon.zero      = flags_q.zero;
  assign mon.negative  = flags_q.negative;
  assign mon.carry     = flags_q.carry;
  assign mon.mismatch  = flags_q.mismatch;
`ifdef PARITY_EN
  assign mon.parity    = flags_q.parity;
`endif

  assign sticky_ov  = sticky_ov_q;
  assign sticky_err = sticky_err_q;

  // Event counters.
  sat_counter #(.CNT_W(CNT_W)) u_txn_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats),
    .inc   (accept_c),
    .count (txn_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_ov_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats),
    .inc   (accept_c & new_flags_c.overflow),
    .count (ov_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats),
    .inc   (accept_c & new_flags_c.mismatch),
    .count (err_count)
  );

endmodule

// File: tb/tb_adder_flag_monitor.sv
// Bench for adder_flag_monitor (WIDTH=8, CNT_W=4): vector table, scoreboard
// queue of expected flag records, and a reference model of sticky flags and
// saturating counters. Honours PARITY_EN when defined.
module tb_adder_flag_monitor;
  import adder_mon_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [WIDTH-1:0] ain;
    logic [WIDTH-1:0] bin;
    logic             ci;
    logic [WIDTH-1:0] result;
    logic             co;
    flag_t            exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic clr_sticky;
  logic clr_stats;
  logic sticky_ov;
  logic sticky_err;
  logic [CNT_W-1:0] txn_count;
  logic [CNT_W-1:0] ov_count;
  logic [CNT_W-1:0] err_count;

  adder_flag_monitor_if #(.WIDTH(WIDTH)) mif ();

  adder_flag_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mon        (mif),
    .clr_sticky (clr_sticky),
    .sticky_ov  (sticky_ov),
    .sticky_err (sticky_err),
    .clr_stats  (clr_stats),
    .txn_count  (txn_count),
    .ov_count   (ov_count),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  flag_t sb[$];
  flag_t cur_exp;
  int    m_txn, m_ov, m_err;
  bit    m_sov, m_serr;
  vec_t  tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic c,
                              input logic [7:0] r, input logic o, input logic ov,
                              input logic z, input logic n, input logic cy,
                              input logic m, input logic p);
    vec_t v;
    v.ain = a; v.bin = b; v.ci = c; v.result = r; v.co = o;
    v.exp = '0;
    v.exp.overflow = ov; v.exp.zero = z; v.exp.negative = n;
    v.exp.carry = cy; v.exp.mismatch = m;
`ifdef PARITY_EN
    v.exp.parity = p;
`else
    if (p) v.exp.zero = z;  // parity column unused in this build
`endif
    return v;
  endfunction

  // Independent flag model used for generated stimulus.
  function automatic flag_t ref_flags(input logic [7:0] a, input logic [7:0] b,
                                      input logic c, input logic [7:0] r, input logic o);
    flag_t f;
    int s;
    int ones;
    f = '0;
    s = int'(a) + int'(b) + int'(c);
    f.overflow = (a[7] == b[7]) && (r[7] != a[7]);
    f.zero     = (r == 8'h00);
    f.negative = r[7];
    f.carry    = o;
    f.mismatch = (s != (int'(o) * 256 + int'(r)));
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(r[i]);
`ifdef PARITY_EN
    f.parity   = (ones % 2) == 1;
`endif
    if (ones < 0) f.zero = 1'b0;
    return f;
  endfunction

  function automatic int sat(input int c, input bit inc, input bit clr);
    if (clr) return inc ? 1 : 0;
    if (inc && c < CMAX) return c + 1;
    return c;
  endfunction

  function automatic flag_t get_act();
    flag_t f;
    f = '0;
    f.overflow = mif.overflow; f.zero = mif.zero; f.negative = mif.negative;
    f.carry = mif.carry; f.mismatch = mif.mismatch;
`ifdef PARITY_EN
    f.parity = mif.parity;
`endif
    return f;
  endfunction

  task automatic drv(input vec_t v);
    mif.in_valid = 1'b1;
    mif.ain = v.ain; mif.bin = v.bin; mif.ci = v.ci;
    mif.result = v.result; mif.co = v.co;
    cur_exp = v.exp;
  endtask

  task automatic drv_gen(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [7:0] r, input logic o);
    vec_t v;
    v.ain = a; v.bin = b; v.ci = c; v.result = r; v.co = o;
    v.exp = ref_flags(a, b, c, r, o);
    drv(v);
  endtask

  // One clock: check presented output, model the edge, check status after it.
  task automatic tick();
    bit exp_rdy, acc, pop;
    #1;
    exp_rdy = (sb.size() == 0) || mif.out_ready;
    if (rst_n) begin
      chk("in_ready", 32'(mif.in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(mif.out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) chk("flags", 32'(get_act()), 32'(sb[0]));
    end
    pop = rst_n && (sb.size() != 0) && mif.out_ready;
    acc = rst_n && mif.in_valid && exp_rdy;
    @(posedge clk);
    if (!rst_n) begin
      sb.delete();
      m_txn = 0; m_ov = 0; m_err = 0; m_sov = 0; m_serr = 0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (acc) sb.push_back(cur_exp);
      m_sov  = (m_sov  && !clr_sticky) || (acc && cur_exp.overflow);
      m_serr = (m_serr && !clr_sticky) || (acc && cur_exp.mismatch);
      m_txn  = sat(m_txn, acc, clr_stats);
      m_ov   = sat(m_ov,  acc && cur_exp.overflow, clr_stats);
      m_err  = sat(m_err, acc && cur_exp.mismatch, clr_stats);
    end
    @(negedge clk);
    chk("sticky_ov", 32'(sticky_ov), 32'(m_sov));
    chk("sticky_err", 32'(sticky_err), 32'(m_serr));
    chk("txn_count", 32'(txn_count), 32'(m_txn));
    chk("ov_count", 32'(ov_count), 32'(m_ov));
    chk("err_count", 32'(err_count), 32'(m_err));
  endtask

  initial begin
    //         ain    bin    ci    res    co  ov z n c m p
    tbl[0] = mk(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1, 0, 1, 0, 0, 1);
    tbl[1] = mk(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1, 0, 1, 0, 0);
    tbl[2] = mk(8'h10, 8'h20, 1'b1, 8'h32, 1'b0, 0, 0, 0, 0, 1, 1);
    tbl[3] = mk(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1, 1, 0, 1, 0, 0);
    tbl[4] = mk(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 0, 0, 0, 0, 0, 1);
    tbl[5] = mk(8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 0, 1, 0, 1, 0, 0);
    tbl[6] = mk(8'h12, 8'h34, 1'b0, 8'h46, 1'b1, 0, 0, 0, 1, 1, 1);
    tbl[7] = mk(8'hC0, 8'hC0, 1'b0, 8'h80, 1'b1, 0, 0, 1, 1, 0, 1);

    rst_n = 1'b0; clr_sticky = 1'b0; clr_stats = 1'b0;
    mif.in_valid = 1'b0; mif.out_ready = 1'b1;
    mif.ain = '0; mif.bin = '0; mif.ci = 1'b0; mif.result = '0; mif.co = 1'b0;
    cur_exp = '0;
    m_txn = 0; m_ov = 0; m_err = 0; m_sov = 0; m_serr = 0;
    @(negedge clk);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(mif.in_ready), 32'd1);
    chk("rst_out_valid", 32'(mif.out_valid), 32'd0);
    @(negedge clk);

    // Signed overflow into negative result.
    drv(tbl[0]); tick(); mif.in_valid = 1'b0;
    chk("t1_flags", 32'(get_act()), 32'(tbl[0].exp));
    chk("t1_sticky_ov", 32'(sticky_ov), 32'd1);
    chk("t1_ov_count", 32'(ov_count), 32'd1);
    // Zero with carry-out.
    drv(tbl[1]); tick(); mif.in_valid = 1'b0;
    chk("t2_flags", 32'(get_act()), 32'(tbl[1].exp));
    // Mismatch, then sticky clear on an idle cycle.
    drv(tbl[2]); tick(); mif.in_valid = 1'b0;
    chk("t3_sticky_err", 32'(sticky_err), 32'd1);
    chk("t3_err_count", 32'(err_count), 32'd1);
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    chk("t3_sticky_cleared", 32'(sticky_err), 32'd0);
    chk("t3_err_count_kept", 32'(err_count), 32'd1);

    // Full table back-to-back.
    for (int i = 0; i < 8; i++) begin
      drv(tbl[i]); tick();
    end
    mif.in_valid = 1'b0; tick();
`ifdef PARITY_EN
    drv(tbl[4]); tick(); mif.in_valid = 1'b0;
    chk("parity_07", 32'(mif.parity), 32'd1);
    tick();
`endif

    // Stall: second transaction held off while output is not drained.
    mif.out_ready = 1'b0;
    drv(tbl[0]); tick();
    drv(tbl[1]);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_in_ready", 32'(mif.in_ready), 32'd0);
      chk("stall_hold", 32'(get_act()), 32'(tbl[0].exp));
    end
    mif.out_ready = 1'b1; tick();   // drain first and accept second together
    mif.in_valid = 1'b0;
    chk("b2b_flags", 32'(get_act()), 32'(tbl[1].exp));
    tick();
    chk("b2b_drained", 32'(mif.out_valid), 32'd0);

    // Saturation.
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drv(tbl[0]); tick();
    end
    mif.in_valid = 1'b0;
    chk("sat_ov_count", 32'(ov_count), 32'd15);
    chk("sat_txn_count", 32'(txn_count), 32'd15);
    clr_stats = 1'b1; drv(tbl[0]); tick(); clr_stats = 1'b0; mif.in_valid = 1'b0;
    chk("clr_acc_ov_count", 32'(ov_count), 32'd1);
    chk("clr_acc_txn_count", 32'(txn_count), 32'd1);
    tick();

    // Reset mid-stream discards the pending output.
    mif.out_ready = 1'b0;
    drv(tbl[3]); tick();
    rst_n = 1'b0; tick();
    #1;
    chk("midrst_out_valid", 32'(mif.out_valid), 32'd0);
    chk("midrst_flags", 32'(get_act()), 32'd0);
    chk("midrst_in_ready", 32'(mif.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; mif.in_valid = 1'b0; mif.out_ready = 1'b1; tick();

    // Random traffic with backpressure and clears.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] a, b, r;
      logic c, o;
      logic [8:0] s;
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      s = 9'(a) + 9'(b) + 9'(c);
      r = s[7:0]; o = s[8];
      if ($urandom_range(0, 3) == 0) r = r ^ 8'($urandom_range(1, 255));
      drv_gen(a, b, c, r, o);
      mif.in_valid  = ($urandom_range(0, 3) != 0);
      mif.out_ready = ($urandom_range(0, 2) != 0);
      clr_sticky    = ($urandom_range(0, 15) == 0);
      clr_stats     = ($urandom_range(0, 15) == 0);
      tick();
    end
    mif.in_valid = 1'b0; clr_sticky = 1'b0; clr_stats = 1'b0; mif.out_ready = 1'b1;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_flag_monitor.md
# adder_flag_monitor

Parametrised, registered status monitor for a WIDTH-bit adder. Each accepted transaction (operands, carry-in, adder result, carry-out) is checked against a reference sum. The block emits per-transaction flags through a one-deep valid/ready output register, holds sticky error flags, and keeps saturating event counters. It sits downstream of the adder datapath and feeds the testbench scoreboard and status readout.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- CNT_W, 16, width of each statistics counter (≥2)

- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  transaction present
- in_ready  output  1  block can accept
- ain  input  WIDTH  operand A
- bin  input  WIDTH  operand B
- ci  input  1  carry-in
- result  input  WIDTH  adder sum output
- co  input  1  adder carry-out
- out_valid  output  1  flags valid
- out_ready  input  1  consumer accepts flags
- overflow  output  1  signed overflow
- zero  output  1  result == 0
- negative  output  1  result[WIDTH-1]
- carry  output  1  registered co
- mismatch  output  1  {co,result} ≠ ain+bin+ci
- parity  output  1  XOR-reduce of result (PARITY_EN only)
- clr_sticky  input  1  clear sticky flags
- sticky_ov  output  1  overflow seen since clear
- sticky_err  output  1  mismatch seen since clear
- clr_stats  input  1  clear all counters
- txn_count  output  CNT_W  accepted transactions
- ov_count  output  CNT_W  overflow transactions
- err_count  output  CNT_W  mismatch transactions

## Operation
- Accept = in_valid & in_ready; in_ready = ~out_valid | out_ready (combinational).
- On accept, compute and register:
  - overflow = (~ain[W-1] & ~bin[W-1] & result[W-1]) | (ain[W-1] & bin[W-1] & ~result[W-1])
  - zero, negative, carry as listed
  - mismatch: reference = zero-extended ain + bin + ci at WIDTH+1 bits, compared with {co,result}
- Output register: set out_valid on accept; clear it when out_ready is high and there is no accept in the same cycle. Flag outputs hold while out_valid & ~out_ready.
- Sticky: sticky_ov |= overflow of the accepted transaction; sticky_err |= its mismatch. When clr_sticky coincides with a setting accept, the set wins (the flag ends 1).
- Counters: txn_count +1 per accept; ov_count +1 per accept with overflow; err_count +1 per accept with mismatch. Each counter saturates at all-ones and does not wrap.
- clr_stats zeroes all counters. If an accept occurs in the same cycle, the counters load that transaction's increment (0 or 1) instead of zero.

## Timing
- Latency: accept at edge k → out_valid and flags visible after edge k; counters and sticky flags update at the same edge.
- Throughput 1/cycle while out_ready=1.
- Reset (rst_n=0 at an edge): out_valid, in-flight flags, sticky flags and counters all go to 0; in_ready=1 from the next cycle.
- Reset mid-transaction discards the pending output. Inputs are ignored while rst_n=0.
- Inputs at an accepting edge must be stable; no input is registered except on accept.

## Configuration
- PARITY_EN defined: parity port present and registered with the other flags. Its value is 1 when result has an odd number of ones. Its reset value is 0.
- PARITY_EN undefined: the parity port and its logic are absent. The flag set is overflow/zero/negative/carry/mismatch only.

## Structure
- Package adder_mon_pkg:
  - flag_t packed struct {overflow, zero, negative, carry, mismatch[, parity]}
  - default CNT_W constant
- One sub-module, sat_counter: parameter CNT_W; inputs clk, rst_n, clr, inc; output count. Saturating, with clear+inc yielding 1. Instantiated three times.

## Test plan
- 0x7F+0x01, ci=0, result=0x80, co=0 → overflow=1, negative=1, zero=0, mismatch=0; sticky_ov=1, ov_count=1.
- 0xFF+0x01, ci=0, result=0x00, co=1 → zero=1, carry=1, overflow=0, mismatch=0.
- 0x10+0x20, ci=1, result=0x32, co=0 → mismatch=1 (expected 0x31), sticky_err=1, err_count=1; clr_sticky on the next idle cycle → sticky_err=0, err_count stays 1.
- out_ready=0 with out_valid=1 → in_ready=0, the second transaction stalls and the flags hold. Raising out_ready and accepting in the same cycle → back-to-back outputs, no loss.
- CNT_W=4, 20 overflow transactions → ov_count=15, txn_count=15. clr_stats with a simultaneous overflow accept → ov_count=1.
- PARITY_EN, result=0x07 → parity=1. rst_n=0 mid-stream → all outputs 0 on the next cycle, in_ready=1.
